// File: rtl/psram_arb.sv
// psram_arb: two-port arbiter that serialises 1/2/4-byte read/write
// requests into a byte-wide PSRAM command stream.
//
// Ports
//   clock, reset_n          : single clock, asynchronous active-low reset
//   reqN_valid/ready        : request handshake (N = 0,1); ready is combinational
//   reqN_write/addr/len/wdata : transfer description, sampled on accept
//   respN_valid             : one-cycle completion pulse for requester N
//   resp_rdata              : little-endian read data, unused lanes zero
//   mem_valid/cmd/addr/wdata: byte command port (EBh read, 38h write)
//   mem_rdata               : read byte, valid the cycle after its command
//
// Build option
//   PSRAM_ARB_RR_EN : when defined, simultaneous requests alternate
//                     (round-robin); otherwise port 0 always wins.
module psram_arb (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_write,
  input  logic [31:0] req0_addr,
  input  logic [1:0]  req0_len,
  input  logic [31:0] req0_wdata,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_write,
  input  logic [31:0] req1_addr,
  input  logic [1:0]  req1_len,
  input  logic [31:0] req1_wdata,
  output logic        resp0_valid,
  output logic        resp1_valid,
  output logic [31:0] resp_rdata,
  output logic        mem_valid,
  output logic [7:0]  mem_cmd,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_WAIT, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_write;
  logic        r_owner;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [1:0]  r_idx;
  logic [1:0]  r_last;
  logic        r_cap;
  logic [1:0]  r_cap_lane;
  logic        w_gnt1;
  logic        w_accept;
  logic [1:0]  w_sel_len;
  logic [31:0] w_wshift;

  // Grant selection: w_gnt1 high means port 1 wins this cycle.
`ifdef PSRAM_ARB_RR_EN
  logic r_prio;  // 1: port 1 preferred on the next simultaneous request

  always_comb w_gnt1 = req1_valid && (!req0_valid || r_prio);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)      r_prio <= 1'b0;
    else if (w_accept) r_prio <= ~w_gnt1;
  end
`else
  always_comb w_gnt1 = req1_valid && !req0_valid;
`endif

  always_comb begin
    w_accept   = (r_state == S_IDLE) && (req0_valid || req1_valid);
    req0_ready = (r_state == S_IDLE) && req0_valid && !w_gnt1;
    req1_ready = (r_state == S_IDLE) && w_gnt1;
    w_sel_len  = w_gnt1 ? req1_len : req0_len;
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_XFER;
      S_XFER: if (r_idx == r_last) w_next = r_write ? S_DONE : S_WAIT;
      S_WAIT: w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Transfer datapath. A read issued in one cycle is captured one cycle
  // later, so the lane index is carried in r_cap_lane alongside r_cap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_write    <= 1'b0;
      r_owner    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_idx      <= '0;
      r_last     <= '0;
      r_cap      <= 1'b0;
      r_cap_lane <= '0;
    end else begin
      r_cap <= (r_state == S_XFER) && !r_write;
      if (r_state == S_XFER) begin
        r_idx      <= r_idx + 2'd1;
        r_cap_lane <= r_idx;
      end
      if (r_cap) r_rdata[{r_cap_lane, 3'b000} +: 8] <= mem_rdata;
      if (w_accept) begin
        r_owner <= w_gnt1;
        r_write <= w_gnt1 ? req1_write : req0_write;
        r_addr  <= w_gnt1 ? req1_addr  : req0_addr;
        r_wdata <= w_gnt1 ? req1_wdata : req0_wdata;
        r_rdata <= '0;
        r_idx   <= '0;
        case (w_sel_len)
          2'b00:   r_last <= 2'd0;
          2'b01:   r_last <= 2'd1;
          default: r_last <= 2'd3;
        endcase
      end
    end
  end

  // Outputs
  always_comb begin
    w_wshift    = r_wdata >> {r_idx, 3'b000};
    mem_valid   = 1'b0;
    mem_cmd     = 8'h00;
    mem_addr    = '0;
    mem_wdata   = 8'h00;
    resp0_valid = (r_state == S_DONE) && !r_owner;
    resp1_valid = (r_state == S_DONE) && r_owner;
    resp_rdata  = r_rdata;
    if (r_state == S_XFER) begin
      mem_valid = 1'b1;
      mem_cmd   = r_write ? 8'h38 : 8'hEB;
      mem_addr  = r_addr + {30'd0, r_idx};
      mem_wdata = r_write ? w_wshift[7:0] : 8'h00;
    end
  end

endmodule

// File: tb/tb_psram_arb.sv
`timescale 1ns/1ps
module tb_psram_arb;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0_valid = 1'b0, req0_write = 1'b0;
  logic [31:0] req0_addr = '0, req0_wdata = '0;
  logic [1:0]  req0_len = '0;
  logic        req1_valid = 1'b0, req1_write = 1'b0;
  logic [31:0] req1_addr = '0, req1_wdata = '0;
  logic [1:0]  req1_len = '0;
  logic        req0_ready, req1_ready, resp0_valid, resp1_valid, mem_valid;
  logic [31:0] resp_rdata, mem_addr;
  logic [7:0]  mem_cmd, mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;

  psram_arb dut (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_len(req0_len), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_len(req1_len), .req1_wdata(req1_wdata),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid), .resp_rdata(resp_rdata),
    .mem_valid(mem_valid), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

`ifdef PSRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct { int unsigned cyc; logic [7:0] cmd; logic [31:0] addr; logic [7:0] wd; } cmd_t;
  typedef struct { int unsigned cyc; int port; logic [31:0] data; } rsp_t;

  cmd_t        cq[$];
  rsp_t        rq[$];
  int          grants[$];
  int unsigned n_cmp = 0, n_fail = 0;
  int unsigned cyc = 0;
  int unsigned free_cyc = 0;
  int          pref = 0;
  logic [7:0]  pend_rd = 8'h00;
  logic        m_idle, e_r0, e_r1, e_mv, e_p0, e_p1;
  int          win;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Backing-store content seen by reads: a fixed function of the address.
  function automatic logic [7:0] memval(input logic [31:0] a);
    if (a == 32'hFFFFFFFF) return 8'h5A;
    if (a == 32'h00000000) return 8'hA5;
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h3C;
  endfunction

  // Reference model of one accepted transfer: byte commands, response, busy time.
  function automatic void accept(input int p, input logic w, input logic [31:0] a,
                                 input logic [1:0] l, input logic [31:0] d);
    int unsigned n = (l == 2'b00) ? 1 : (l == 2'b01) ? 2 : 4;
    logic [31:0] rd = '0;
    cmd_t c;
    rsp_t r;
    for (int unsigned i = 0; i < n; i++) begin
      c.cyc  = cyc + 1 + i;
      c.cmd  = w ? 8'h38 : 8'hEB;
      c.addr = a + i;
      c.wd   = w ? d[8*i +: 8] : 8'h00;
      cq.push_back(c);
      if (!w) rd[8*i +: 8] = memval(a + i);
    end
    r.cyc  = cyc + n + (w ? 32'd1 : 32'd2);
    r.port = p;
    r.data = rd;
    rq.push_back(r);
    free_cyc = cyc + n + (w ? 32'd2 : 32'd3);
    pref = 1 - p;
    grants.push_back(p);
  endfunction

  // Monitor / scoreboard, sampled mid-cycle; also drives the memory read byte.
  always @(negedge clock) begin
    if (reset_n) begin
      m_idle = (cyc >= free_cyc);
      if (req0_valid && req1_valid) win = RR ? pref : 0;
      else                          win = req1_valid ? 1 : 0;
      e_r0 = m_idle && req0_valid && (win == 0);
      e_r1 = m_idle && req1_valid && (win == 1);
      chk("req0_ready", 32'(req0_ready), 32'(e_r0));
      chk("req1_ready", 32'(req1_ready), 32'(e_r1));
      if (req0_valid && req0_ready)      accept(0, req0_write, req0_addr, req0_len, req0_wdata);
      else if (req1_valid && req1_ready) accept(1, req1_write, req1_addr, req1_len, req1_wdata);

      e_mv = (cq.size() > 0) && (cq[0].cyc == cyc);
      chk("mem_valid", 32'(mem_valid), 32'(e_mv));
      if (e_mv) begin
        chk("mem_cmd", 32'(mem_cmd), 32'(cq[0].cmd));
        chk("mem_addr", mem_addr, cq[0].addr);
        chk("mem_wdata", 32'(mem_wdata), 32'(cq[0].wd));
        void'(cq.pop_front());
      end else begin
        chk("mem_cmd_idle", 32'(mem_cmd), 32'h0);
      end

      e_p0 = (rq.size() > 0) && (rq[0].cyc == cyc) && (rq[0].port == 0);
      e_p1 = (rq.size() > 0) && (rq[0].cyc == cyc) && (rq[0].port == 1);
      chk("resp0_valid", 32'(resp0_valid), 32'(e_p0));
      chk("resp1_valid", 32'(resp1_valid), 32'(e_p1));
      if (e_p0 || e_p1) begin
        chk("resp_rdata", resp_rdata, rq[0].data);
        void'(rq.pop_front());
      end
    end
    mem_rdata = pend_rd;
    pend_rd   = (mem_valid && mem_cmd == 8'hEB) ? memval(mem_addr) : 8'($urandom);
  end

  // Present one request and hold it until accepted; entered just after a rising edge.
  task automatic send(input int p, input logic w, input logic [31:0] a,
                      input logic [1:0] l, input logic [31:0] d);
    int unsigned t = 0;
    if (p == 0) begin
      req0_valid = 1'b1; req0_write = w; req0_addr = a; req0_len = l; req0_wdata = d;
    end else begin
      req1_valid = 1'b1; req1_write = w; req1_addr = a; req1_len = l; req1_wdata = d;
    end
    forever begin
      @(negedge clock);
      if ((p == 0 && req0_ready) || (p == 1 && req1_ready)) break;
      t++;
      if (t > 200) begin
        n_cmp++; n_fail++;
        $display("FAIL accept_timeout: port %0d not accepted within %0d cycles", p, t);
        break;
      end
    end
    @(posedge clock); #1;
    if (p == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
  endtask

  task automatic rnd_send(input int p);
    logic [31:0] a = $urandom;
    if ($urandom_range(0, 3) == 0) a = 32'hFFFFFFFC + $urandom_range(0, 3);
    send(p, 1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)), $urandom);
  endtask

  task automatic drain();
    int unsigned t = 0;
    while ((cq.size() > 0 || rq.size() > 0) && t < 100) begin
      @(posedge clock); #1; t++;
    end
    if (cq.size() > 0 || rq.size() > 0) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_timeout: %0d cmds / %0d resps outstanding", cq.size(), rq.size());
      cq.delete(); rq.delete();
    end
    repeat (3) @(posedge clock);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    chk("rst_mem_valid", 32'(mem_valid), 32'h0);
    chk("rst_mem_cmd", 32'(mem_cmd), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_valid", 32'({resp1_valid, resp0_valid}), 32'h0);
    @(negedge clock); #2 reset_n = 1'b1;
    @(posedge clock); #1;

    // 4-byte write, then 2-byte read wrapping past the top of the address space
    send(0, 1'b1, 32'h00000100, 2'b10, 32'hDDCCBBAA);
    send(1, 1'b0, 32'hFFFFFFFF, 2'b01, 32'h0);
    drain();

    // Both ports continuously valid with four single-byte reads each
    grants.delete();
    fork
      begin for (int i = 0; i < 4; i++) send(0, 1'b0, 32'h1000 + i, 2'b00, 32'h0); end
      begin for (int i = 0; i < 4; i++) send(1, 1'b0, 32'h2000 + i, 2'b00, 32'h0); end
    join
    drain();
    chk("grant_count", grants.size(), 32'd8);
    for (int i = 0; i < 8 && i < grants.size(); i++)
      chk("grant_order", grants[i], RR ? (i % 2) : (i < 4 ? 0 : 1));

    // Back-to-back single-byte reads on port 0
    send(0, 1'b0, 32'h3000, 2'b00, 32'h0);
    send(0, 1'b0, 32'h3001, 2'b00, 32'h0);
    drain();

    // Reset while byte 2 of a 4-byte write is on the command port
    send(0, 1'b1, 32'h4000, 2'b10, 32'h44332211);
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_mem_valid", 32'(mem_valid), 32'h0);
    chk("midrst_mem_cmd", 32'(mem_cmd), 32'h0);
    chk("midrst_mem_addr", mem_addr, 32'h0);
    chk("midrst_resp", 32'({resp1_valid, resp0_valid}), 32'h0);
    cq.delete(); rq.delete();
    free_cyc = 0; pref = 0;
    @(negedge clock); #2 reset_n = 1'b1;
    @(posedge clock); #1;
    send(0, 1'b0, 32'h5000, 2'b10, 32'h0);
    send(1, 1'b1, 32'h6000, 2'b01, 32'hCAFEBEEF);
    drain();

    // Randomised traffic on both ports
    fork
      begin
        for (int i = 0; i < 25; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clock);
          #1 rnd_send(0);
        end
      end
      begin
        for (int i = 0; i < 25; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clock);
          #1 rnd_send(1);
        end
      end
    join
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
